// File: rtl/team_05_patgen_pkg.sv
// Shared types and constants for the Team 05 GPIO self-test pattern generator.
// Holds the FSM state encoding, the LFSR tap positions, the DONE signature,
// the pause pin index and the LFSR next-value helper.
package team_05_patgen_pkg;

  // Encoding is visible on dbg_state when TEAM05_PATGEN_DBG_EN is defined.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWalk = 2'd1,
    StLfsr = 2'd2,
    StDone = 2'd3
  } patgen_state_e;

  localparam int unsigned LFSR_TAP_HI = 32;
  localparam int unsigned LFSR_TAP_LO = 19;
  localparam logic [32:0] DONE_PATTERN = 33'h1_5555_5555;
  localparam int unsigned PIN_PAUSE = 0;

  // Fibonacci step for the 33-bit LFSR (taps 33 and 20, one-based).
  function automatic logic [32:0] lfsr_next(input logic [32:0] v);
    return {v[31:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/team_05_sync2.sv
// Generic 1-bit two-flop synchronizer with synchronous active-high reset.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset (clears both flops)
//   d   - asynchronous input
//   q   - synchronized output (2 clk latency)
module team_05_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/team_05_gpio_patgen.sv
// Team 05 GPIO self-test pattern generator.
// Drives the 34-bit team GPIO bus with a walking-one sweep, an LFSR run and a
// fixed DONE signature. Bit 0 of the bus stays an input (pause request).
// Ports:
//   clk       - project clock
//   rst       - synchronous active-high reset
//   en        - project enable; dropping it returns to IDLE
//   gpio_in   - pad inputs, only bit 0 (asynchronous pause) is used
//   gpio_out  - pad outputs, {pattern[32:0], 1'b0}
//   gpio_oeb  - output-enable bar, all ones in IDLE, 34'h1 otherwise
//   done_o    - high while in DONE
// Optional build macro TEAM05_PATGEN_DBG_EN adds:
//   dbg_state - current state encoding (IDLE=0, WALK=1, LFSR=2, DONE=3)
//   dbg_step  - walk index or LFSR index, 0 in IDLE and DONE
module team_05_gpio_patgen
  import team_05_patgen_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 40,
  parameter int unsigned LFSR_STEPS  = 16,
  parameter logic [32:0] LFSR_SEED   = 33'h0_A5A5_A5A5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [33:0] gpio_in,
  output logic [33:0] gpio_out,
  output logic [33:0] gpio_oeb,
  output logic        done_o
`ifdef TEAM05_PATGEN_DBG_EN
  ,
  output logic [1:0]  dbg_state,
  output logic [5:0]  dbg_step
`endif
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
  // Wide enough for walk indices 0..32 and LFSR indices 0..LFSR_STEPS-1.
  localparam int unsigned StepW = (LFSR_STEPS > 64) ? $clog2(LFSR_STEPS) : 6;

  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("team_05_gpio_patgen: HOLD_CYCLES must be >= 2");
  end
  if (LFSR_SEED == 33'h0) begin : g_bad_seed
    $error("team_05_gpio_patgen: LFSR_SEED must be nonzero");
  end
  if (LFSR_STEPS < 1) begin : g_bad_steps
    $error("team_05_gpio_patgen: LFSR_STEPS must be >= 1");
  end

  patgen_state_e    state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [StepW-1:0] step_q, step_d;
  logic [32:0]      lfsr_q, lfsr_d;
  logic [32:0]      pat_q, pat_d;
  logic [33:0]      oeb_q, oeb_d;
  logic             done_q, done_d;
  logic             pause;
  logic             hold_last;

  // Only the pause pin is an input; the rest of the bus is driven by us.
  logic unused_gpio_in;
  assign unused_gpio_in = ^gpio_in[33:1];

  team_05_sync2 u_pause_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_in[PIN_PAUSE]),
    .q   (pause)
  );

  assign hold_last = (hold_q == HoldW'(HOLD_CYCLES - 1));

  // State register (all outputs registered alongside).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
      step_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      pat_q   <= '0;
      oeb_q   <= 34'h3_FFFF_FFFF;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      lfsr_q  <= lfsr_d;
      pat_q   <= pat_d;
      oeb_q   <= oeb_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    step_d  = step_q;
    lfsr_d  = lfsr_q;
    pat_d   = pat_q;
    if (state_q != StIdle && !en) begin
      state_d = StIdle;
      hold_d  = '0;
      step_d  = '0;
      lfsr_d  = LFSR_SEED;
      pat_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            state_d = StWalk;
            hold_d  = '0;
            step_d  = '0;
            pat_d   = 33'h1;
          end
        end
        StWalk: begin
          if (!pause) begin
            if (hold_last) begin
              hold_d = '0;
              if (pat_q[32]) begin
                state_d = StLfsr;
                step_d  = '0;
                lfsr_d  = LFSR_SEED;
                pat_d   = LFSR_SEED;
              end else begin
                step_d = step_q + 1'b1;
                pat_d  = pat_q << 1;
              end
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        StLfsr: begin
          if (!pause) begin
            if (hold_last) begin
              hold_d = '0;
              if (step_q == StepW'(LFSR_STEPS - 1)) begin
                state_d = StDone;
                step_d  = '0;
                pat_d   = DONE_PATTERN;
              end else begin
                step_d = step_q + 1'b1;
                lfsr_d = lfsr_next(lfsr_q);
                pat_d  = lfsr_next(lfsr_q);
              end
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        StDone: ;
        default: ;
      endcase
    end
  end

  // Output logic, computed from the next state so it registers in step with it.
  always_comb begin
    oeb_d  = (state_d == StIdle) ? 34'h3_FFFF_FFFF : 34'h1;
    done_d = (state_d == StDone);
  end

  assign gpio_out = {pat_q, 1'b0};
  assign gpio_oeb = oeb_q;
  assign done_o   = done_q;

`ifdef TEAM05_PATGEN_DBG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_state <= 2'd0;
      dbg_step  <= 6'd0;
    end else begin
      dbg_state <= state_d;
      dbg_step  <= step_d[5:0];
    end
  end
`endif

endmodule

// File: tb/tb_team_05_gpio_patgen.sv
// Directed self-checking bench for team_05_gpio_patgen.
// u0: HOLD_CYCLES=4, default seed and LFSR_STEPS=16.
// u1: HOLD_CYCLES=2, LFSR_SEED=1, LFSR_STEPS=21.
module tb_team_05_gpio_patgen;

  logic        clk;
  logic        rst0, en0, rst1, en1;
  logic [33:0] gin0, gin1;
  logic [33:0] out0, oeb0, out1, oeb1;
  logic        done0, done1;
`ifdef TEAM05_PATGEN_DBG_EN
  logic [1:0]  dst0, dst1;
  logic [5:0]  dsp0, dsp1;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [32:0] SEED0 = 33'h0_A5A5_A5A5;
  logic [32:0] tab0 [0:15];
  logic [32:0] tab1 [0:20];

  team_05_gpio_patgen #(
    .HOLD_CYCLES (4),
    .LFSR_STEPS  (16),
    .LFSR_SEED   (SEED0)
  ) u0 (
    .clk       (clk),
    .rst       (rst0),
    .en        (en0),
    .gpio_in   (gin0),
    .gpio_out  (out0),
    .gpio_oeb  (oeb0),
    .done_o    (done0)
`ifdef TEAM05_PATGEN_DBG_EN
    ,
    .dbg_state (dst0),
    .dbg_step  (dsp0)
`endif
  );

  team_05_gpio_patgen #(
    .HOLD_CYCLES (2),
    .LFSR_STEPS  (21),
    .LFSR_SEED   (33'h1)
  ) u1 (
    .clk       (clk),
    .rst       (rst1),
    .en        (en1),
    .gpio_in   (gin1),
    .gpio_out  (out1),
    .gpio_oeb  (oeb1),
    .done_o    (done1)
`ifdef TEAM05_PATGEN_DBG_EN
    ,
    .dbg_state (dst1),
    .dbg_step  (dsp1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] lfsr_nx(input logic [32:0] v);
    return {v[31:0], v[32] ^ v[19]};
  endfunction

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    en0  = 1'b0;
    gin0 = '0;
    tick();
    rst0 = 1'b0;
  endtask

  task automatic test_reset();
    reset0();
    checks++;
    if (out0 !== 34'h0 || oeb0 !== 34'h3_FFFF_FFFF || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%h oeb=%h done=%b want out=0 oeb=3ffffffff done=0",
               out0, oeb0, done0);
    end
    // en low with random pins on the bus: stays idle
    gin0 = 34'h3_FFFF_FFFE;
    tick();
    tick();
    checks++;
    if (out0 !== 34'h0 || oeb0 !== 34'h3_FFFF_FFFF || done0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: out=%h oeb=%h done=%b want idle values", out0, oeb0, done0);
    end
    gin0 = '0;
  endtask

  // Full sequence on u0; k counts edges after en is first sampled high.
  task automatic test_sequence();
    logic [33:0] exp;
    logic        exp_done;
    int          e_state, e_step;
    reset0();
    en0 = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k <= 132) begin
        exp = {33'h1 << ((k - 1) / 4), 1'b0};
        exp_done = 1'b0; e_state = 1; e_step = (k - 1) / 4;
      end else if (k <= 196) begin
        exp = {tab0[(k - 133) / 4], 1'b0};
        exp_done = 1'b0; e_state = 2; e_step = (k - 133) / 4;
      end else begin
        exp = 34'h2_AAAA_AAAA;
        exp_done = 1'b1; e_state = 3; e_step = 0;
      end
      checks++;
      if (out0 !== exp || oeb0 !== 34'h1 || done0 !== exp_done) begin
        errors++;
        $display("FAIL seq k=%0d: out=%h oeb=%h done=%b want out=%h oeb=1 done=%b",
                 k, out0, oeb0, done0, exp, exp_done);
      end
`ifdef TEAM05_PATGEN_DBG_EN
      checks++;
      if (dst0 !== 2'(e_state) || dsp0 !== 6'(e_step)) begin
        errors++;
        $display("FAIL dbg k=%0d: state=%0d step=%0d want state=%0d step=%0d",
                 k, dst0, dsp0, e_state, e_step);
      end
`else
      if (e_state < 0 || e_step < 0) $display("unexpected index");
`endif
      // hand-computed spot checks
      if (k == 4 || k == 8 || k == 133) begin
        checks++;
        if (out0 !== ((k == 4) ? 34'h2 : (k == 8) ? 34'h4 : 34'h1_4B4B_4B4A)) begin
          errors++;
          $display("FAIL spot k=%0d: out=%h", k, out0);
        end
      end
    end
  endtask

  // Pause mid-WALK at pattern 33'h10 for 50 cycles of the pin.
  task automatic test_pause();
    int w;
    logic [33:0] exp;
    reset0();
    en0 = 1'b1;
    for (int k = 1; k <= 186; k++) begin
      tick();
      w = (k <= 20) ? k : (k <= 70) ? 20 : k - 50;
      exp = (w <= 132) ? {33'h1 << ((w - 1) / 4), 1'b0} : {tab0[(w - 133) / 4], 1'b0};
      checks++;
      if (out0 !== exp || oeb0 !== 34'h1 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL pause k=%0d: out=%h oeb=%h done=%b want out=%h", k, out0, oeb0, done0,
                 exp);
      end
      if (k == 18) gin0[0] = 1'b1;
      if (k == 68) gin0[0] = 1'b0;
    end
  endtask

  task automatic test_en_drop();
    logic [33:0] exp;
    reset0();
    en0 = 1'b1;
    repeat (140) tick();
    checks++;
    if (out0 !== {tab0[1], 1'b0}) begin
      errors++;
      $display("FAIL pre_drop: out=%h want %h", out0, {tab0[1], 1'b0});
    end
    en0 = 1'b0;
    tick();
    checks++;
    if (out0 !== 34'h0 || oeb0 !== 34'h3_FFFF_FFFF || done0 !== 1'b0) begin
      errors++;
      $display("FAIL en_drop: out=%h oeb=%h done=%b want idle values", out0, oeb0, done0);
    end
    en0 = 1'b1;
    for (int k = 1; k <= 133; k++) begin
      tick();
      exp = (k <= 132) ? {33'h1 << ((k - 1) / 4), 1'b0} : 34'h1_4B4B_4B4A;
      checks++;
      if (out0 !== exp || oeb0 !== 34'h1) begin
        errors++;
        $display("FAIL restart k=%0d: out=%h oeb=%h want out=%h oeb=1", k, out0, oeb0, exp);
      end
    end
  endtask

  // u1 runs to DONE, then takes rst with en still high.
  task automatic test_lfsr_done_rst();
    logic [33:0] exp;
    logic        exp_done;
    rst1 = 1'b1;
    en1  = 1'b1;
    gin1 = '0;
    tick();
    rst1 = 1'b0;
    // en already high: the first released edge enters WALK
    for (int k = 1; k <= 112; k++) begin
      tick();
      if (k <= 66) begin
        exp = {33'h1 << ((k - 1) / 2), 1'b0}; exp_done = 1'b0;
      end else if (k <= 108) begin
        exp = {tab1[(k - 67) / 2], 1'b0}; exp_done = 1'b0;
      end else begin
        exp = 34'h2_AAAA_AAAA; exp_done = 1'b1;
      end
      checks++;
      if (out1 !== exp || oeb1 !== 34'h1 || done1 !== exp_done) begin
        errors++;
        $display("FAIL u1 k=%0d: out=%h oeb=%h done=%b want out=%h done=%b",
                 k, out1, oeb1, done1, exp, exp_done);
      end
      if (k == 105 || k == 107) begin
        checks++;
        if (out1 !== ((k == 105) ? 34'h10_0000 : 34'h20_0002)) begin
          errors++;
          $display("FAIL lfsr_idx k=%0d: out=%h", k, out1);
        end
      end
      if (k == 110) gin1[0] = 1'b1;
    end
    rst1 = 1'b1;
    tick();
    checks++;
    if (out1 !== 34'h0 || oeb1 !== 34'h3_FFFF_FFFF || done1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_done: out=%h oeb=%h done=%b want idle values", out1, oeb1, done1);
    end
    rst1 = 1'b0;
    gin1 = '0;
    tick();
    checks++;
    if (out1 !== 34'h2 || oeb1 !== 34'h1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL walk_after_rst: out=%h oeb=%h done=%b want out=2 oeb=1 done=0",
               out1, oeb1, done1);
    end
  endtask

  initial begin
    rst0 = 1'b1; en0 = 1'b0; gin0 = '0;
    rst1 = 1'b1; en1 = 1'b0; gin1 = '0;
    tab0[0] = SEED0;
    for (int i = 1; i < 16; i++) tab0[i] = lfsr_nx(tab0[i - 1]);
    tab1[0] = 33'h1;
    for (int i = 1; i < 21; i++) tab1[i] = lfsr_nx(tab1[i - 1]);
    tick();
    test_reset();
    test_sequence();
    test_pause();
    test_en_drop();
    test_lfsr_done_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/team_05_gpio_patgen.md
Name: team_05_gpio_patgen

Overview:
Self-test pattern generator inside the Team 05 user project. It drives the 34-bit team GPIO bus (Caravel {mprj_io[37:5], mprj_io[0]}) with a deterministic sequence that the Caravel-level bench samples and checks.
- Sequence: a walking-one sweep, then an LFSR run, then a fixed DONE signature.
- The block sits between the project enable/GPIO muxing and the pads.
- GPIO bit 0 is an input: an external pause request.

Parameters:
HOLD_CYCLES, 40, clk cycles each pattern is held on the pins (1 us at 40 MHz); legal range >= 2
LFSR_STEPS, 16, number of LFSR patterns emitted, including the seed; legal range >= 1
LFSR_SEED, 33'h0_A5A5_A5A5, initial LFSR value; must be nonzero

Ports:
clk  input  1  project clock, 40 MHz
rst  input  1  synchronous, active-high reset
en  input  1  project enable from the management SoC (Wishbone/LA select)
gpio_in  input  34  pad inputs; only bit 0 (pause, asynchronous) is used
gpio_out  output  34  pad outputs
gpio_oeb  output  34  output-enable bar (0 = drive)
done_o  output  1  high while in DONE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state = IDLE, gpio_out = 34'h0, gpio_oeb = 34'h3_FFFF_FFFF, done_o = 0, hold counter = 0, LFSR = LFSR_SEED, pause synchronizer = 0.
- Pin map:
  - gpio_out = {pattern[32:0], 1'b0}.
  - Outside IDLE, gpio_oeb = 34'h1 (bit 0 stays an input).
  - In IDLE, gpio_oeb is all ones.
- States: IDLE, WALK, LFSR, DONE. All outputs are registered.
- IDLE:
  - pattern = 0.
  - en = 1 moves to WALK. On the first WALK cycle, pattern = 33'h1, so gpio_out = 34'h2 (latency 1 clk from en sampled high).
- WALK:
  - Each pattern is held HOLD_CYCLES cycles, then pattern shifts left by 1.
  - After pattern bit 32 has been held, the next cycle enters LFSR with pattern = LFSR_SEED.
  - Total WALK duration is 33*HOLD_CYCLES cycles.
- LFSR:
  - Fibonacci, 33 bits, taps 33 and 20.
  - next = {lfsr[31:0], lfsr[32]^lfsr[19]}.
  - Advances once per HOLD_CYCLES, for LFSR_STEPS patterns. Index 0 is the seed.
  - After the last pattern's hold completes, the next state is DONE.
- DONE:
  - pattern = 33'h1_5555_5555, done_o = 1.
  - Stays in DONE until en = 0.
- en = 0 in any non-IDLE state: next cycle is IDLE and outputs return to their reset values. The LFSR reloads LFSR_SEED and the hold counter clears.
- Pause:
  - gpio_in[0] passes through a 2-flop synchronizer before use.
  - While the synchronized pause is 1, the hold counter, state and LFSR freeze, and the outputs hold.
  - Effect latency is 2 clk from a pin change. Pause has no effect in IDLE or DONE.
- Priority, highest first: rst, then en = 0, then pause, then normal advance.
- Hold counter:
  - Width is $clog2(HOLD_CYCLES).
  - Counts 0..HOLD_CYCLES-1. Hitting HOLD_CYCLES-1 triggers an advance and wraps to 0.
- Parameter checks: a zero seed or HOLD_CYCLES < 2 is rejected by an elaboration-time $error.

Optional Feature:
TEAM05_PATGEN_DBG_EN
- Defined:
  - Adds output dbg_state (2 bits: IDLE=0, WALK=1, LFSR=2, DONE=3).
  - Adds output dbg_step (6 bits): walk index 0..32 or LFSR index 0..LFSR_STEPS-1; 0 in IDLE and DONE.
  - Both are registered and update in the same cycle as the pattern.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package team_05_patgen_pkg holds:
  - state enum (2-bit)
  - LFSR_TAP_HI = 32, LFSR_TAP_LO = 19
  - DONE_PATTERN = 33'h1_5555_5555
  - PIN_PAUSE = 0
- Sub-module team_05_sync2 is the generic 1-bit 2-flop synchronizer with synchronous active-high reset, used for pause.

Test Plan:
1. HOLD_CYCLES=4, rst then en=1 at cycle N:
   - gpio_out=34'h2 for cycles N+1..N+4, then 34'h4 for N+5..N+8.
   - gpio_oeb=34'h1 throughout; after 132 cycles, gpio_out={LFSR_SEED,1'b0}.
2. LFSR_SEED=1, LFSR_STEPS=21, HOLD_CYCLES=2:
   - LFSR index 19 gives pattern 33'h8_0000; index 20 gives 33'h10_0001.
   - DONE follows: gpio_out=34'h2_AAAA_AAAA, done_o=1.
3. Pause: assert gpio_in[0] mid-WALK at pattern 33'h10:
   - Outputs freeze starting 2 cycles later.
   - Deassert after 50 cycles; the remaining hold count resumes exactly, and total WALK length is 33*HOLD+50(±sync).
4. en drop mid-LFSR:
   - Next cycle: gpio_out=0, gpio_oeb=34'h3_FFFF_FFFF, done_o=0.
   - Re-enable: the sequence restarts at 34'h2 and LFSR index 0 equals the seed.
5. rst asserted in DONE with en=1:
   - Next cycle shows reset values.
   - After rst release with en still 1, WALK begins 1 cycle later.
6. With TEAM05_PATGEN_DBG_EN: dbg_state walks 0→1→2→3 and dbg_step tracks indices. Without the macro: compile, and the scenario 1 outputs are identical.
